// File: rtl/snake_state_regfile.sv
// snake_state_regfile: game-state register file for the snake processor.
//
// Holds a board of NUM_CELLS cells (CELL_W bits each) plus a bank of 32-bit scalars. The scalars,
// in address order, are head_pos[P], length[P], stage and head_dir[P]. Cells and scalars share one
// write address space. The whole state is also presented on a flat bus for the VGA renderer.
//
// Address map (B = NUM_CELLS, P = NUM_PLAYERS):
//   0 .. B-1            cells
//   B .. B+P-1          head_pos[p]
//   B+P .. B+2P-1       length[p]
//   B+2P                stage
//   B+2P+1 .. B+3P      head_dir[p]   (B+3P is the last valid index)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   enable     in   write strobe
//   index      in   write address (IDX_W bits, compared unsigned at full width)
//   value_in   in   write data; cells take value_in[CELL_W-1:0]
//   rd_index   in   read address
//   rd_data    out  registered read data (cells zero-extended, out-of-range reads give 0)
//   clear_req  in   single-cycle board-clear request
//   busy       out  clear sweep in progress (exactly NUM_CELLS cycles)
//   done       out  one-cycle pulse after the sweep
//   wr_err     out  one-cycle pulse for a dropped write (out of range, or cell write while busy)
//   value_out  out  flat state bus: cells from the LSB up, then the scalars in address order
//   occ_count  out  number of nonzero cells (only with SNAKE_REGFILE_OCCUPANCY_EN defined)
//
// Optional feature macro: SNAKE_REGFILE_OCCUPANCY_EN adds the occ_count output and its counter.

module snake_state_regfile #(
  parameter int unsigned NUM_CELLS   = 100,
  parameter int unsigned CELL_W      = 2,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned IDX_W       = 32
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic [IDX_W-1:0]                                 index,
  input  logic [31:0]                                      value_in,
  input  logic [IDX_W-1:0]                                 rd_index,
  output logic [31:0]                                      rd_data,
  input  logic                                             clear_req,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             wr_err,
  output logic [NUM_CELLS*CELL_W+(3*NUM_PLAYERS+1)*32-1:0] value_out
`ifdef SNAKE_REGFILE_OCCUPANCY_EN
  ,
  output logic [$clog2(NUM_CELLS+1)-1:0]                   occ_count
`endif
);

  localparam int unsigned NumScal = 3 * NUM_PLAYERS + 1;
  localparam int unsigned CntW    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  localparam logic [IDX_W-1:0] NumCellsIdx = IDX_W'(NUM_CELLS);
  localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(NUM_CELLS + NumScal - 1);
  localparam logic [CntW-1:0]  LastCell    = CntW'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDone  = 2'd2
  } clr_state_e;

  clr_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [CELL_W-1:0] cells_q [NUM_CELLS];
  logic [CELL_W-1:0] cells_d [NUM_CELLS];
  logic [31:0]       scal_q  [NumScal];
  logic [31:0]       scal_d  [NumScal];

  logic        wr_err_q, wr_err_d;
  logic [31:0] rd_data_q, rd_data_d;

`ifdef SNAKE_REGFILE_OCCUPANCY_EN
  localparam int unsigned OccW = $clog2(NUM_CELLS + 1);
  logic [OccW-1:0] occ_q, occ_d;
`endif

  // --------------------------------------------------------------------------
  // Clear-sweep FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        // clear_req is deliberately ignored here and in StDone: no restart, no queueing.
        if (cnt_q == LastCell) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == StSweep);
  assign done = (state_q == StDone);

  // --------------------------------------------------------------------------
  // Write path, sweep clearing and occupancy tracking
  // --------------------------------------------------------------------------
  always_comb begin
    cells_d  = cells_q;
    scal_d   = scal_q;
    wr_err_d = 1'b0;
`ifdef SNAKE_REGFILE_OCCUPANCY_EN
    occ_d    = occ_q;
`endif

    if (enable) begin
      if (index > LastIdx) begin
        wr_err_d = 1'b1;
      end else if (index < NumCellsIdx) begin
        // The sweep owns the board while busy; a concurrent cell write is dropped.
        if (busy) begin
          wr_err_d = 1'b1;
        end else begin
          for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (index == IDX_W'(i)) begin
              cells_d[i] = value_in[CELL_W-1:0];
`ifdef SNAKE_REGFILE_OCCUPANCY_EN
              if ((value_in[CELL_W-1:0] != '0) && (cells_q[i] == '0)) begin
                occ_d = occ_q + OccW'(1);
              end else if ((value_in[CELL_W-1:0] == '0) && (cells_q[i] != '0)) begin
                occ_d = occ_q - OccW'(1);
              end
`endif
            end
          end
        end
      end else begin
        // Scalars are writable at any time, including during a sweep.
        for (int unsigned j = 0; j < NumScal; j++) begin
          if (index == IDX_W'(NUM_CELLS + j)) begin
            scal_d[j] = value_in;
          end
        end
      end
    end

    // Cell writes are blocked while busy, so the sweep never collides with them.
    if (busy) begin
      for (int unsigned i = 0; i < NUM_CELLS; i++) begin
        if (cnt_q == CntW'(i)) begin
          cells_d[i] = '0;
`ifdef SNAKE_REGFILE_OCCUPANCY_EN
          if (cells_q[i] != '0) begin
            occ_d = occ_q - OccW'(1);
          end
`endif
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: samples the pre-write contents, so read-during-write returns the old value.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (rd_index == IDX_W'(i)) begin
        rd_data_d = 32'(cells_q[i]);
      end
    end
    for (int unsigned j = 0; j < NumScal; j++) begin
      if (rd_index == IDX_W'(NUM_CELLS + j)) begin
        rd_data_d = scal_q[j];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
      for (int unsigned i = 0; i < NUM_CELLS; i++) begin
        cells_q[i] <= '0;
      end
      for (int unsigned j = 0; j < NumScal; j++) begin
        scal_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_err_q  <= wr_err_d;
      rd_data_q <= rd_data_d;
      cells_q   <= cells_d;
      scal_q    <= scal_d;
    end
  end

`ifdef SNAKE_REGFILE_OCCUPANCY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_count = occ_q;
`endif

  assign wr_err  = wr_err_q;
  assign rd_data = rd_data_q;

  // --------------------------------------------------------------------------
  // Flat state bus
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell_bus
    assign value_out[CELL_W*g +: CELL_W] = cells_q[g];
  end

  for (genvar g = 0; g < NumScal; g++) begin : g_scal_bus
    assign value_out[NUM_CELLS*CELL_W + 32*g +: 32] = scal_q[g];
  end

endmodule

// File: tb/tb_snake_state_regfile.sv
// Directed testbench for snake_state_regfile at default parameters. Read results go through a
// scoreboard queue; the state bus is compared against a bench-side model of the register file.

module tb_snake_state_regfile;

  localparam int unsigned B    = 100;
  localparam int unsigned NS   = 7;
  localparam int unsigned BUSW = 424;

  logic            clock     = 1'b0;
  logic            reset     = 1'b1;
  logic            enable    = 1'b0;
  logic [31:0]     index     = '0;
  logic [31:0]     value_in  = '0;
  logic [31:0]     rd_index  = '0;
  logic            clear_req = 1'b0;
  logic [31:0]     rd_data;
  logic            busy;
  logic            done;
  logic            wr_err;
  logic [BUSW-1:0] value_out;
`ifdef SNAKE_REGFILE_OCCUPANCY_EN
  logic [6:0]      occ_count;
`endif

  snake_state_regfile dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .index     (index),
    .value_in  (value_in),
    .rd_index  (rd_index),
    .rd_data   (rd_data),
    .clear_req (clear_req),
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err),
    .value_out (value_out)
`ifdef SNAKE_REGFILE_OCCUPANCY_EN
    ,
    .occ_count (occ_count)
`endif
  );

  always #5 clock = ~clock;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [1:0]  m_cells [B];
  logic [31:0] m_scal  [NS];
  logic [31:0] rd_q[$];

  task automatic check(input string tag, input logic [BUSW-1:0] obs, input logic [BUSW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BUSW-1:0] model_bus();
    logic [BUSW-1:0] v;
    v = '0;
    for (int i = 0; i < B; i++) v[2*i +: 2] = m_cells[i];
    for (int j = 0; j < NS; j++) v[2*B + 32*j +: 32] = m_scal[j];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < B; i++) m_cells[i] = '0;
    for (int j = 0; j < NS; j++) m_scal[j] = '0;
  endfunction

  // Accepted write only.
  function automatic void model_wr(input int unsigned idx, input logic [31:0] val);
    if (idx < B) m_cells[idx] = val[1:0];
    else m_scal[idx-B] = val;
  endfunction

  task automatic wr(input logic [31:0] idx, input logic [31:0] val);
    enable   = 1'b1;
    index    = idx;
    value_in = val;
    step();
    enable   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] idx, input logic [31:0] exp);
    rd_index = idx;
    rd_q.push_back(exp);
    step();
    check(tag, rd_data, rd_q.pop_front());
  endtask

  int n_busy;
  int n_done;

  initial begin
    model_clear();

    // Asynchronous reset, away from a clock edge.
    #3 reset = 1'b0;
    #1;
    check("rst_value_out", value_out, '0);
    check("rst_rd_data", rd_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_err", wr_err, 1'b0);
    step();
    reset = 1'b1;

    // Cell write and read-back.
    wr(5, 32'h3);
    model_wr(5, 32'h3);
    check("cell5_bus", value_out[11:10], 2'b11);
    check("bus_after_cell5", value_out, model_bus());
    rd_check("rd_cell5", 5, 32'h3);

    // Scalar writes: stage and head_dir[1].
    wr(104, 32'h7);
    model_wr(104, 32'h7);
    check("stage_bus", value_out[359:328], 32'h7);
    rd_check("rd_stage", 104, 32'h7);
    wr(106, 32'hDEAD_BEEF);
    model_wr(106, 32'hDEAD_BEEF);
    check("head_dir1_bus", value_out[423:392], 32'hDEAD_BEEF);
    rd_check("rd_head_dir1", 106, 32'hDEAD_BEEF);

    // Out-of-range writes: one just past the map, one aliasing cell 5 in the low bits.
    wr(107, 32'hFFFF_FFFF);
    check("wr_err_107", wr_err, 1'b1);
    check("bus_after_107", value_out, model_bus());
    step();
    check("wr_err_107_clear", wr_err, 1'b0);
    wr(32'h8000_0005, 32'h0);
    check("wr_err_high_bits", wr_err, 1'b1);
    check("bus_after_high_bits", value_out, model_bus());
    rd_check("rd_200", 200, 32'h0);
    rd_check("rd_high_bits", 32'h8000_0068, 32'h0);

    // Read and write to the same index in one cycle returns the old value.
    enable   = 1'b1;
    index    = 5;
    value_in = 32'h1;
    rd_index = 5;
    rd_q.push_back({30'd0, m_cells[5]});
    step();
    enable = 1'b0;
    model_wr(5, 32'h1);
    check("rd_during_wr", rd_data, rd_q.pop_front());
    check("bus_after_rdw", value_out, model_bus());

    // Fill the board, then clear while writing cell 7 in the accepting cycle.
    for (int i = 0; i < B; i++) begin
      wr(i, 32'h2);
      model_wr(i, 32'h2);
    end
    check("bus_filled", value_out, model_bus());
    clear_req = 1'b1;
    enable    = 1'b1;
    index     = 7;
    value_in  = 32'h1;
    step();
    clear_req = 1'b0;
    enable    = 1'b0;
    model_wr(7, 32'h1);
    check("clr_accept_write_lands", value_out[15:14], 2'b01);
    check("clr_accept_busy", busy, 1'b1);

    n_busy = 0;
    for (int c = 0; c < 300 && busy === 1'b1; c++) begin
      n_busy++;
      clear_req = (c == 10);
      enable    = (c == 20) || (c == 30);
      index     = (c == 20) ? 32'd3 : 32'd100;
      value_in  = (c == 20) ? 32'h1 : 32'h55;
      step();
      clear_req = 1'b0;
      enable    = 1'b0;
      if (c == 20) check("sweep_cell_wr_err", wr_err, 1'b1);
      if (c == 30) begin
        check("sweep_scalar_no_err", wr_err, 1'b0);
        model_wr(100, 32'h55);
      end
    end
    for (int i = 0; i < B; i++) m_cells[i] = '0;
    check("busy_cycles", n_busy, 100);
    check("done_pulse", done, 1'b1);
    check("bus_after_sweep", value_out, model_bus());
    step();
    check("done_one_cycle", done, 1'b0);
    check("no_restart", busy, 1'b0);
    rd_check("rd_cell50_cleared", 50, 32'h0);
    rd_check("rd_scalar_kept", 100, 32'h55);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 5; i++) wr(i, 32'h1);
    wr(104, 32'h9);
    rd_index  = 104;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 40; c++) step();
    check("mid_sweep_busy", busy, 1'b1);
    check("mid_sweep_rd", rd_data, 32'h9);
    reset = 1'b0;
    #1;
    model_clear();
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_bus", value_out, model_bus());
    check("rst_mid_rd", rd_data, 32'h0);
    check("rst_mid_done", done, 1'b0);
    step();
    reset = 1'b1;
    rd_index = 0;
    n_done = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check("no_done_after_rst", n_done, 0);
    check("idle_after_rst", busy, 1'b0);

`ifdef SNAKE_REGFILE_OCCUPANCY_EN
    check("occ_reset", occ_count, 7'd0);
    wr(3, 32'h1);
    check("occ_1", occ_count, 7'd1);
    wr(4, 32'h1);
    check("occ_2", occ_count, 7'd2);
    wr(4, 32'h1);
    check("occ_2_again", occ_count, 7'd2);
    wr(3, 32'h0);
    check("occ_back_1", occ_count, 7'd1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 300 && busy === 1'b1; c++) step();
    check("occ_after_sweep_done", done, 1'b1);
    check("occ_after_sweep", occ_count, 7'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
